// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler
// In-order DRAM command scheduler with an open-page policy. Accepts one decoded
// request at a time, keeps the open row of every bank, and emits registered
// one-cycle PRECHARGE / ACTIVATE / READ / WRITE strobes. Column commands are
// spaced so read and write bursts never overlap on the DIMM data bus.
//
// Ports
//   clk_in, rst_N_in        clock, synchronous active-low reset
//   req_valid_in/ready_out  request handshake (ready only while idle)
//   req_write_in            1 = write, 0 = read
//   req_row/col/bg/ba_in    target address
//   req_data_in             write line (ignored for reads)
//   cmd_valid_out           one-cycle command strobe
//   cmd_out                 0=READ 1=WRITE 2=ACTIVATE 3=PRECHARGE
//   cmd_bg/ba/row/col_out   address of the request in flight
//   cmd_val_out             write line, updated only when a WRITE issues
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | ready for a new request
// S_DECIDE   | classify hit / closed / conflict and issue first command
// S_PRE_WAIT | precharge issued, waiting before activate
// S_ACT_WAIT | activate issued, waiting before column command
// S_COL_WAIT | column command pending on bus guards, or issued (exit next)
module dram_cmd_scheduler #(
  parameter int CAS_LATENCY        = 22,
  parameter int ACTIVATION_LATENCY = 8,
  parameter int PRECHARGE_LATENCY  = 5,
  parameter int BANK_GROUPS        = 2,
  parameter int BANKS_PER_GROUP    = 4,
  parameter int ROW_BITS           = 8,
  parameter int COL_BITS           = 4,
  parameter int BURST_CYCLES       = 8
) (
  input  logic                               clk_in,
  input  logic                               rst_N_in,
  input  logic                               req_valid_in,
  output logic                               req_ready_out,
  input  logic                               req_write_in,
  input  logic [ROW_BITS-1:0]                req_row_in,
  input  logic [COL_BITS-1:0]                req_col_in,
  input  logic [$clog2(BANK_GROUPS)-1:0]     req_bg_in,
  input  logic [$clog2(BANKS_PER_GROUP)-1:0] req_ba_in,
  input  logic [7:0][63:0]                   req_data_in,
  output logic                               cmd_valid_out,
  output logic [2:0]                         cmd_out,
  output logic [$clog2(BANK_GROUPS)-1:0]     cmd_bg_out,
  output logic [$clog2(BANKS_PER_GROUP)-1:0] cmd_ba_out,
  output logic [ROW_BITS-1:0]                cmd_row_out,
  output logic [COL_BITS-1:0]                cmd_col_out,
  output logic [7:0][63:0]                   cmd_val_out
);

  localparam int BG_W      = $clog2(BANK_GROUPS);
  localparam int BA_W      = $clog2(BANKS_PER_GROUP);
  localparam int NUM_BANKS = BANK_GROUPS * BANKS_PER_GROUP;
  localparam int BK_W      = $clog2(NUM_BANKS);
  localparam int GRD_W     = $clog2(CAS_LATENCY + BURST_CYCLES + 1);
  localparam int TMR_MAX   = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ?
                             ACTIVATION_LATENCY : PRECHARGE_LATENCY;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);

  localparam logic [2:0] CMD_RD  = 3'd0;
  localparam logic [2:0] CMD_WR  = 3'd1;
  localparam logic [2:0] CMD_ACT = 3'd2;
  localparam logic [2:0] CMD_PRE = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_DECIDE, S_PRE_WAIT, S_ACT_WAIT, S_COL_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic                 write_q;
  logic [ROW_BITS-1:0]  row_q;
  logic [COL_BITS-1:0]  col_q;
  logic [BG_W-1:0]      bg_q;
  logic [BA_W-1:0]      ba_q;
  logic [7:0][63:0]     data_q;
  logic [NUM_BANKS-1:0] open_valid_q;
  logic [ROW_BITS-1:0]  open_row_q [NUM_BANKS];
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [GRD_W-1:0]     gap_q;
  logic [GRD_W-1:0]     wtr_q;
  logic                 col_sent_q, col_sent_d;

  logic                 accept;
  logic [BK_W-1:0]      bank_idx;
  logic                 hit;
  logic                 guard_ok;
  logic                 issue;
  logic [2:0]           issue_cmd;
  logic                 issue_col;
  logic                 set_open;
  logic                 clr_open;

  assign req_ready_out = rst_N_in && (state_q == S_IDLE);
  assign accept        = req_valid_in && req_ready_out;
  assign bank_idx      = BK_W'(bg_q) * BK_W'(BANKS_PER_GROUP) + BK_W'(ba_q);
  assign hit           = open_valid_q[bank_idx] && (open_row_q[bank_idx] == row_q);
  // gap_q spaces any two column commands; wtr_q keeps a write clear of the
  // previous read's data return window.
  assign guard_ok      = (gap_q == '0) && (!write_q || (wtr_q == '0));

  assign cmd_bg_out  = bg_q;
  assign cmd_ba_out  = ba_q;
  assign cmd_row_out = row_q;
  assign cmd_col_out = col_q;

  always_comb begin
    state_d    = state_q;
    tmr_d      = (tmr_q != '0) ? tmr_q - 1'b1 : '0;
    col_sent_d = col_sent_q;
    issue      = 1'b0;
    issue_cmd  = CMD_RD;
    issue_col  = 1'b0;
    set_open   = 1'b0;
    clr_open   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_DECIDE;
          col_sent_d = 1'b0;
        end
      end
      S_DECIDE: begin
        if (hit) begin
          state_d   = S_COL_WAIT;
          issue_col = guard_ok;
        end else if (open_valid_q[bank_idx]) begin
          issue     = 1'b1;
          issue_cmd = CMD_PRE;
          clr_open  = 1'b1;
          tmr_d     = TMR_W'(PRECHARGE_LATENCY - 1);
          state_d   = S_PRE_WAIT;
        end else begin
          issue     = 1'b1;
          issue_cmd = CMD_ACT;
          set_open  = 1'b1;
          tmr_d     = TMR_W'(ACTIVATION_LATENCY - 1);
          state_d   = S_ACT_WAIT;
        end
      end
      S_PRE_WAIT: begin
        if (tmr_q == '0) begin
          issue     = 1'b1;
          issue_cmd = CMD_ACT;
          set_open  = 1'b1;
          tmr_d     = TMR_W'(ACTIVATION_LATENCY - 1);
          state_d   = S_ACT_WAIT;
        end
      end
      S_ACT_WAIT: begin
        // the column command may be decided in the same cycle the wait ends
        if (tmr_q == '0) begin
          state_d   = S_COL_WAIT;
          issue_col = guard_ok;
        end
      end
      S_COL_WAIT: begin
        // stay one cycle after the strobe so ready rises after the command
        if (col_sent_q) state_d = S_IDLE;
        else            issue_col = guard_ok;
      end
      default: state_d = S_IDLE;
    endcase
    if (issue_col) begin
      issue      = 1'b1;
      issue_cmd  = write_q ? CMD_WR : CMD_RD;
      col_sent_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      state_q       <= S_IDLE;
      write_q       <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
      bg_q          <= '0;
      ba_q          <= '0;
      data_q        <= '0;
      open_valid_q  <= '0;
      for (int i = 0; i < NUM_BANKS; i++) open_row_q[i] <= '0;
      tmr_q         <= '0;
      gap_q         <= '0;
      wtr_q         <= '0;
      col_sent_q    <= 1'b0;
      cmd_valid_out <= 1'b0;
      cmd_out       <= '0;
      cmd_val_out   <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      col_sent_q <= col_sent_d;
      if (accept) begin
        write_q <= req_write_in;
        row_q   <= req_row_in;
        col_q   <= req_col_in;
        bg_q    <= req_bg_in;
        ba_q    <= req_ba_in;
        data_q  <= req_data_in;
      end
      if (set_open) begin
        open_valid_q[bank_idx] <= 1'b1;
        open_row_q[bank_idx]   <= row_q;
      end
      if (clr_open) open_valid_q[bank_idx] <= 1'b0;
      cmd_valid_out <= issue;
      if (issue) cmd_out <= issue_cmd;
      if (issue_col && write_q) cmd_val_out <= data_q;
      if (issue_col)         gap_q <= GRD_W'(BURST_CYCLES - 1);
      else if (gap_q != '0)  gap_q <= gap_q - 1'b1;
      if (issue_col && !write_q) wtr_q <= GRD_W'(CAS_LATENCY + BURST_CYCLES - 1);
      else if (wtr_q != '0)      wtr_q <= wtr_q - 1'b1;
    end
  end

endmodule
